am_modulator: RTL and testbench

Transmit-side counterpart of the AM demodulator in the SDR chain. It takes signed audio samples and applies them as a zero-order-held envelope, using a modulation-depth control. It generates an internal NCO carrier (phase accumulator plus quarter-wave sine LUT) and outputs the amplitude-modulated real carrier `rf_out = envelope * cos(phase)` through a 4-stage pipeline, with a valid strobe. It feeds the DAC or upconversion path.

---
 rtl/am_modulator.sv | 274 +++++++++++++++++++++++++++
 tb/tb_am_modulator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/am_modulator.sv
// -----------------------------------------------------------------------------
// am_modulator
//
// Transmit-side AM modulator for the SDR chain. Signed audio samples are
// turned into an unsigned, zero-order-held envelope using a Q0.8 modulation
// depth. An internal NCO (phase accumulator plus quarter-wave sine table)
// generates the carrier. The module outputs rf_out = envelope * cos(phase)
// through a four-register pipeline (A: capture, B: table, C: multiply,
// D: scale), together with a valid strobe.
//
// Optional feature, selected by the macro AM_MOD_IQ_OUT_EN:
//   When the macro is defined, a second table read port and a second
//   multiplier produce iq_out = envelope * sin(phase). This uses the
//   un-offset accumulator phase, has the same latency as rf_out and shares
//   rf_valid. When the macro is undefined, neither the port nor the logic
//   exists.
//
// Parameters
//   INPUT_WIDTH     audio / output sample width (signed)
//   PHASE_WIDTH     phase accumulator width
//   LUT_ADDR_WIDTH  quarter-wave table address width
//
// Ports
//   clk          clock
//   arst         asynchronous reset, active high
//   en           advance the NCO and launch one output sample
//   phase_clr    synchronous clear of the phase accumulator (wins over en)
//   phase_inc    unsigned carrier frequency word
//   audio        signed audio sample
//   audio_valid  capture audio into the envelope register
//   depth        unsigned modulation depth, Q0.8
//   rf_out       signed modulated carrier
//   rf_valid     rf_out (and iq_out) hold a new sample
//   iq_out       signed envelope * sin(phase)   (AM_MOD_IQ_OUT_EN only)
// -----------------------------------------------------------------------------
module am_modulator #(
    parameter int INPUT_WIDTH    = 12,
    parameter int PHASE_WIDTH    = 24,
    parameter int LUT_ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          en,
    input  logic                          phase_clr,
    input  logic [PHASE_WIDTH-1:0]        phase_inc,
    input  logic signed [INPUT_WIDTH-1:0] audio,
    input  logic                          audio_valid,
    input  logic [7:0]                    depth,
    output logic signed [INPUT_WIDTH-1:0] rf_out,
    output logic                          rf_valid
`ifdef AM_MOD_IQ_OUT_EN
    ,
    output logic signed [INPUT_WIDTH-1:0] iq_out
`endif
);

    localparam int ENV_W    = INPUT_WIDTH + 1;        // unsigned envelope
    localparam int MUL_W    = INPUT_WIDTH + 9;        // audio * {0,depth}
    localparam int PROD_W   = 2 * INPUT_WIDTH + 1;    // envelope * carrier
    localparam int PH_W     = LUT_ADDR_WIDTH + 2;     // full-circle phase bits
    localparam int LUT_SIZE = 1 << LUT_ADDR_WIDTH;

    localparam logic [ENV_W-1:0] ENV_MID = ENV_W'(1) << (INPUT_WIDTH - 1);
    // +pi/2 expressed on the full-circle phase bits (quadrant LSB set).
    localparam logic [PH_W-1:0]  PH_QUARTER = PH_W'(1) << LUT_ADDR_WIDTH;

    localparam real PI = 3.14159265358979323846;

    // -------------------------------------------------------------------------
    // Quarter-wave sine table, sampled at the centre of each bin so that the
    // quadrant mirroring below is exact:
    //   T[k] = round((2^(INPUT_WIDTH-1)-1) * sin(pi/2 * (k+0.5) / LUT_SIZE))
    // -------------------------------------------------------------------------
    function automatic logic [INPUT_WIDTH-2:0] lut_entry(input int k);
        real amp;
        real ang;
        int  v;
        amp = real'((1 << (INPUT_WIDTH - 1)) - 1);
        ang = PI / 2.0 * (real'(k) + 0.5) / real'(LUT_SIZE);
        v   = $rtoi(amp * $sin(ang) + 0.5);
        return (INPUT_WIDTH-1)'(v);
    endfunction

    // Odd quadrants read the table backwards; N-1-k is just ~k.
    function automatic logic [LUT_ADDR_WIDTH-1:0] fold_index(
        input logic                      mirror,
        input logic [LUT_ADDR_WIDTH-1:0] k
    );
        return mirror ? ~k : k;
    endfunction

    // Upper half circle is the negated table value.
    function automatic logic signed [INPUT_WIDTH-1:0] apply_sign(
        input logic                   negate,
        input logic [INPUT_WIDTH-2:0] mag
    );
        return negate ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    // NOTE: the table is a constant ROM built from constants, so it has no
    // reset and no write port; only the pipeline registers below are reset.
    logic [INPUT_WIDTH-2:0] lut_rom [LUT_SIZE];

    for (genvar g = 0; g < LUT_SIZE; g++) begin : g_lut
        assign lut_rom[g] = lut_entry(g);
    end

    // -------------------------------------------------------------------------
    // Envelope: 2^(W-1) + floor(audio * depth / 256), held between strobes.
    // The signed result ranges from 8 to 4087 (defaults), so wrapping the sum
    // to ENV_W bits yields the correct unsigned value.
    // -------------------------------------------------------------------------
    logic signed [MUL_W-1:0] mod_prod;
    logic [ENV_W-1:0]        env_next;
    logic [ENV_W-1:0]        env;

    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        mod_prod = MUL_W'(audio) * MUL_W'($signed({1'b0, depth}));
        env_next = ENV_MID + ENV_W'(mod_prod >>> 8);
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values. Stage A depends on this to see the old
    // env and the pre-increment acc.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            env <= ENV_MID;
        end else if (audio_valid) begin
            env <= env_next;
        end
    end

    // -------------------------------------------------------------------------
    // Phase accumulator
    // -------------------------------------------------------------------------
    logic [PHASE_WIDTH-1:0] acc;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc <= '0;
        end else if (phase_clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + phase_inc;
        end
    end

    // -------------------------------------------------------------------------
    // Stage A: capture phase and envelope.
    // Adding 2^(PHASE_WIDTH-2) never carries out of the bits below the top
    // PH_W, so the cosine offset is applied to those bits alone.
    // -------------------------------------------------------------------------
    logic [PH_W-1:0]  ph_a;
    logic [ENV_W-1:0] env_a;
    logic             v_a;
`ifdef AM_MOD_IQ_OUT_EN
    logic [PH_W-1:0]  ph_s_a;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ph_a  <= '0;
            env_a <= '0;
            v_a   <= 1'b0;
`ifdef AM_MOD_IQ_OUT_EN
            ph_s_a <= '0;
`endif
        end else begin
            v_a <= en;
            if (en) begin
                ph_a  <= acc[PHASE_WIDTH-1 -: PH_W] + PH_QUARTER;
                env_a <= env;
`ifdef AM_MOD_IQ_OUT_EN
                ph_s_a <= acc[PHASE_WIDTH-1 -: PH_W];
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage B: table lookup with quadrant folding
    // -------------------------------------------------------------------------
    logic [LUT_ADDR_WIDTH-1:0]     lut_idx;
    logic signed [INPUT_WIDTH-1:0] car_next;
    logic signed [INPUT_WIDTH-1:0] car_b;
    logic [ENV_W-1:0]              env_b;
    logic                          v_b;
`ifdef AM_MOD_IQ_OUT_EN
    logic [LUT_ADDR_WIDTH-1:0]     lut_s_idx;
    logic signed [INPUT_WIDTH-1:0] car_s_next;
    logic signed [INPUT_WIDTH-1:0] car_s_b;
`endif

    always_comb begin
        lut_idx  = fold_index(ph_a[LUT_ADDR_WIDTH], ph_a[LUT_ADDR_WIDTH-1:0]);
        car_next = apply_sign(ph_a[LUT_ADDR_WIDTH+1], lut_rom[lut_idx]);
`ifdef AM_MOD_IQ_OUT_EN
        lut_s_idx  = fold_index(ph_s_a[LUT_ADDR_WIDTH], ph_s_a[LUT_ADDR_WIDTH-1:0]);
        car_s_next = apply_sign(ph_s_a[LUT_ADDR_WIDTH+1], lut_rom[lut_s_idx]);
`endif
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            car_b <= '0;
            env_b <= '0;
            v_b   <= 1'b0;
`ifdef AM_MOD_IQ_OUT_EN
            car_s_b <= '0;
`endif
        end else begin
            v_b <= v_a;
            if (v_a) begin
                car_b <= car_next;
                env_b <= env_a;
`ifdef AM_MOD_IQ_OUT_EN
                car_s_b <= car_s_next;
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage C: envelope (zero-extended to signed) times carrier
    // -------------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod_c;
    logic                     v_c;
`ifdef AM_MOD_IQ_OUT_EN
    logic signed [PROD_W-1:0] prod_s_c;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            prod_c <= '0;
            v_c    <= 1'b0;
`ifdef AM_MOD_IQ_OUT_EN
            prod_s_c <= '0;
`endif
        end else begin
            v_c <= v_b;
            if (v_b) begin
                prod_c <= PROD_W'($signed({1'b0, env_b})) * PROD_W'(car_b);
`ifdef AM_MOD_IQ_OUT_EN
                prod_s_c <= PROD_W'($signed({1'b0, env_b})) * PROD_W'(car_s_b);
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage D: rescale. |envelope * carrier| < 2^(2W-1), so the floor-shifted
    // result always fits in W bits and truncation is safe.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rf_out   <= '0;
            rf_valid <= 1'b0;
`ifdef AM_MOD_IQ_OUT_EN
            iq_out   <= '0;
`endif
        end else begin
            rf_valid <= v_c;
            if (v_c) begin
                rf_out <= INPUT_WIDTH'(prod_c >>> INPUT_WIDTH);
`ifdef AM_MOD_IQ_OUT_EN
                iq_out <= INPUT_WIDTH'(prod_s_c >>> INPUT_WIDTH);
`endif
            end
        end
    end

endmodule

// File: tb/tb_am_modulator.sv
// -----------------------------------------------------------------------------
// tb_am_modulator
//
// Directed and randomized stimulus for am_modulator. The reference model
// treats the carrier as round(A * cos(2*pi*(i+0.5)/2^(LUT_ADDR_WIDTH+2))) over
// the full circle and the envelope as plain integer arithmetic. Expected
// samples travel through a queue that matches the output latency.
// -----------------------------------------------------------------------------
module tb_am_modulator;

    localparam int  IW  = 12;
    localparam int  PW  = 24;
    localparam int  LAW = 8;
    localparam int  LAT = 4;
    localparam real PI  = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 arst;
    logic                 en;
    logic                 phase_clr;
    logic [PW-1:0]        phase_inc;
    logic signed [IW-1:0] audio;
    logic                 audio_valid;
    logic [7:0]           depth;
    logic signed [IW-1:0] rf_out;
    logic                 rf_valid;
`ifdef AM_MOD_IQ_OUT_EN
    logic signed [IW-1:0] iq_out;
`endif

    am_modulator #(
        .INPUT_WIDTH   (IW),
        .PHASE_WIDTH   (PW),
        .LUT_ADDR_WIDTH(LAW)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .en         (en),
        .phase_clr  (phase_clr),
        .phase_inc  (phase_inc),
        .audio      (audio),
        .audio_valid(audio_valid),
        .depth      (depth),
        .rf_out     (rf_out),
        .rf_valid   (rf_valid)
`ifdef AM_MOD_IQ_OUT_EN
        ,
        .iq_out     (iq_out)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------ model
    typedef struct {
        bit v;
        int val;
    } exp_t;

    exp_t   pipe_q[$];
    longint acc_m;
    int     env_m;
    int     hold_m;
    int     exp_v;
    int     errors = 0;
    int     checks = 0;

    function automatic int cos_val(input longint a);
        int  i;
        real s;
        i = int'(a >> (PW - LAW - 2));
        s = real'((1 << (IW - 1)) - 1) *
            $cos(2.0 * PI * (real'(i) + 0.5) / real'(1 << (LAW + 2)));
        if (s >= 0.0) return $rtoi(s + 0.5);
        return -$rtoi(0.5 - s);
    endfunction

    task automatic model_reset();
        acc_m  = 0;
        env_m  = 1 << (IW - 1);
        hold_m = 0;
        pipe_q.delete();
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then check.
    task automatic tick(input bit e, input bit clr, input int inc,
                        input bit av, input int aud, input int dep);
        exp_t ent;
        en          = e;
        phase_clr   = clr;
        phase_inc   = PW'(inc);
        audio_valid = av;
        audio       = IW'(aud);
        depth       = 8'(dep);
        @(posedge clk);
        ent.v   = e;
        ent.val = 0;
        if (e) ent.val = int'((longint'(env_m) * longint'(cos_val(acc_m))) >>> IW);
        pipe_q.push_back(ent);
        if (pipe_q.size() > LAT) void'(pipe_q.pop_front());
        if (av) env_m = (1 << (IW - 1)) + ((aud * dep) >>> 8);
        if (clr) acc_m = 0;
        else if (e) acc_m = (acc_m + longint'(inc)) % (longint'(1) << PW);
        #1;
        exp_v = 0;
        if (pipe_q.size() == LAT && pipe_q[0].v) begin
            exp_v  = 1;
            hold_m = pipe_q[0].val;
        end
        check("rf_valid", 32'(rf_valid), exp_v);
        check("rf_out", 32'(rf_out), hold_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        int pat[4] = '{1023, -3, -1024, 3};
        int aud_r;

        arst = 1'b1; en = 1'b0; phase_clr = 1'b0; phase_inc = '0;
        audio = '0; audio_valid = 1'b0; depth = '0;
        model_reset();
        #12;
        check("reset_rf_valid", 32'(rf_valid), 0);
        check("reset_rf_out", 32'(rf_out), 0);
        arst = 1'b0;

        // Pure carrier at fclk/4 with depth 0.
        for (int i = 0; i < 12; i++) begin
            tick(1, 0, 1 << 22, 0, 0, 0);
            if (i < LAT - 1) check("carrier_latency", 32'(rf_valid), 0);
            else check("carrier_seq", 32'(rf_out), pat[(i - (LAT - 1)) % 4]);
        end
        idle(4);

        // Strobe on the same edge as en: the old envelope is used, the new one next.
        tick(0, 1, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 2047, 255);
        tick(1, 0, 0, 0, 0, 0);
        idle(1);
        tick(0, 0, 0, 0, 0, 0);
        check("hold_old_env", 32'(rf_out), 1023);
        tick(0, 0, 0, 0, 0, 0);
        check("hold_peak_4087", 32'(rf_out), 2042);

        // Minimum envelope (8).
        tick(0, 0, 0, 1, -2048, 255);
        tick(1, 0, 0, 0, 0, 0);
        idle(3);
        check("env_min_8", 32'(rf_out), 3);

        // Depth 0 gives the unmodulated envelope whatever the audio.
        aud_r = int'($urandom_range(0, 4095)) - 2048;
        tick(0, 0, 0, 1, aud_r, 0);
        tick(1, 0, 0, 0, 0, 0);
        idle(3);
        check("env_depth0", 32'(rf_out), 1023);

        // Gapped en: 1,0,1,1.
        tick(1, 0, 1 << 22, 0, 0, 0);
        tick(0, 0, 1 << 22, 0, 0, 0);
        tick(1, 0, 1 << 22, 0, 0, 0);
        tick(1, 0, 1 << 22, 0, 0, 0);
        idle(5);

        // phase_clr together with en.
        tick(1, 0, 1 << 22, 0, 0, 0);
        tick(1, 1, 1 << 22, 0, 0, 0);
        tick(1, 0, 1 << 22, 0, 0, 0);
        idle(3);
        check("phase_clr_zero", 32'(rf_out), 1023);

        // Reset with the pipeline full.
        for (int i = 0; i < 5; i++)
            tick(1, 0, int'($urandom_range(0, (1 << PW) - 1)), 1,
                 int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 255)));
        arst = 1'b1;
        #1;
        check("midreset_rf_valid", 32'(rf_valid), 0);
        check("midreset_rf_out", 32'(rf_out), 0);
        model_reset();
        #2;
        arst = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            tick(1, 0, 1 << 20, 0, 0, 0);
            if (i < LAT - 1) check("postreset_no_valid", 32'(rf_valid), 0);
        end

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, (1 << PW) - 1)),
                 $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 255)));
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
